// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  // Iteration counter width; a 2-bit operand still needs one counter bit.
  function automatic int count_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/adder_subtractor_rc.sv
// Ripple-carry adder/subtractor: {co,g} = a + (b ^ {sub}) + (ci ^ sub).
module adder_subtractor_rc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             ci,
  output logic [WIDTH-1:0] g,
  output logic             co
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   c;

  always_comb begin
    bx   = b ^ {WIDTH{sub}};
    g    = '0;
    c    = '0;
    c[0] = ci ^ sub;
    for (int i = 0; i < WIDTH; i++) begin
      g[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    co = c[WIDTH];
  end

endmodule

// File: rtl/divider_restoring_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// valid/ready on both the operand and the result side.
module divider_restoring_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = count_width(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   g;
  logic             co;
  logic             take;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  assign s = {r_q, q_q[WIDTH-1]};

  adder_subtractor_rc #(
    .WIDTH (WIDTH + 1)
  ) u_trial_sub (
    .a   (s),
    .b   ({1'b0, div_q}),
    .sub (1'b1),
    .ci  (1'b0),
    .g   (g),
    .co  (co)
  );

  // g[WIDTH] is zero whenever co is set, so gating on it never changes the decision.
  always_comb begin
    take   = co & ~g[WIDTH];
    r_next = take ? g[WIDTH-1:0] : s[WIDTH-1:0];
    q_next = {q_q[WIDTH-2:0], take};
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    q_d         = q_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (divisor != '0) begin
            div_d   = divisor;
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = RUN;
          end else begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end
        end
      end
      RUN: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quotient_d  = q_next;
          remainder_d = r_next;
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // A zero-divisor result enters with out_valid low and raises it one edge later.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      q_q         <= q_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
